// File: rtl/rf_status_report_pkg.sv
// Shared constants, types and frame builder for the RF status report path.
package rf_status_report_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STS_W  = 16;
    localparam int unsigned CMD_W  = 64;
    localparam int unsigned CODE_W = 32;

    localparam logic [BYTE_W-1:0] HDR_BYTE = 8'h1c;

    localparam logic [CODE_W-1:0] CMD_QUERY  = 32'h1b1b_3f01;
    localparam logic [CODE_W-1:0] CMD_PER_EN = 32'h1b1b_3f02;
    localparam logic [CODE_W-1:0] CMD_CHG_EN = 32'h1b1b_3f03;

    localparam logic [BYTE_W-1:0] CAUSE_QUERY    = 8'h01;
    localparam logic [BYTE_W-1:0] CAUSE_PERIODIC = 8'h02;
    localparam logic [BYTE_W-1:0] CAUSE_CHANGE   = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Element i is the i-th byte on the wire.
    typedef logic [7:0][BYTE_W-1:0] frame_t;

    function automatic frame_t build_frame(input logic [BYTE_W-1:0] seq,
                                           input logic [BYTE_W-1:0] cause,
                                           input logic [STS_W-1:0]  sts,
                                           input logic [BYTE_W-1:0] ctrl);
        frame_t f;
        f[0] = HDR_BYTE;
        f[1] = HDR_BYTE;
        f[2] = seq;
        f[3] = cause;
        f[4] = sts[15:8];
        f[5] = sts[7:0];
        f[6] = ctrl;
        f[7] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
        return f;
    endfunction

endpackage

// File: rtl/rf_sts_sync.sv
// Multi-bit synchronizer for the asynchronous status pins plus a change detector.
module rf_sts_sync #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_20mhz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sts_s,
    output logic             chg_c
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sts_prev;

    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sts_prev <= '0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            sts_prev <= sync_q[STAGES-1];
        end
    end

    assign sts_s = sync_q[STAGES-1];
    assign chg_c = (sts_s != sts_prev);

endmodule

// File: rtl/rf_status_report.sv
// RF status report: snapshots status pins and control echo into an 8-byte
// frame and streams it to the UART transmitter on query, period or change.
module rf_status_report
    import rf_status_report_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 20000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_20mhz,
    input  logic              rst_n,
    input  logic              rv_uart_vld,
    input  logic [CMD_W-1:0]  rv_uart_data,
    input  logic [STS_W-1:0]  rf_sts_in,
    input  logic [BYTE_W-1:0] ctrl_echo,
    input  logic              tx_byte_rdy,
    output logic              tx_byte_vld,
    output logic [BYTE_W-1:0] tx_byte_data,
    output logic              busy,
    output logic [BYTE_W-1:0] seq_num
);

    localparam int unsigned CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [STS_W-1:0]  sts_s;
    logic              chg_c;
    logic [CODE_W-1:0] cmd_code_c;
    logic              cmd_query_c, cmd_per_c, cmd_chg_c, cmd_bit_c;
    logic              per_tick_c, in_load_c, any_pend_c;
    logic [BYTE_W-1:0] cause_c;
    logic              unused_data_bits;

    state_t            state;
    logic              per_en, chg_en;
    logic              pend_q, pend_c, pend_p;
    logic [CNT_W-1:0]  per_cnt;
    frame_t            frame;
    logic [2:0]        idx;

    rf_sts_sync #(
        .WIDTH  (STS_W),
        .STAGES (SYNC_STAGES)
    ) u_sts_sync (
        .clk_20mhz (clk_20mhz),
        .rst_n     (rst_n),
        .din       (rf_sts_in),
        .sts_s     (sts_s),
        .chg_c     (chg_c)
    );

    assign cmd_code_c       = rv_uart_data[63:32];
    assign cmd_bit_c        = rv_uart_data[0];
    assign unused_data_bits = ^rv_uart_data[31:1];
    assign cmd_query_c      = rv_uart_vld && (cmd_code_c == CMD_QUERY);
    assign cmd_per_c        = rv_uart_vld && (cmd_code_c == CMD_PER_EN);
    assign cmd_chg_c        = rv_uart_vld && (cmd_code_c == CMD_CHG_EN);

    assign per_tick_c = per_en && (per_cnt == CNT_W'(PERIOD_CYC - 1));
    assign in_load_c  = (state == ST_LOAD);
    assign any_pend_c = pend_q || pend_c || pend_p;
    assign cause_c    = pend_q ? CAUSE_QUERY : (pend_c ? CAUSE_CHANGE : CAUSE_PERIODIC);

    // Command decode, period counter and pending flags.
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            per_en  <= 1'b0;
            chg_en  <= 1'b0;
            per_cnt <= '0;
            pend_q  <= 1'b0;
            pend_c  <= 1'b0;
            pend_p  <= 1'b0;
        end else begin
            if (cmd_per_c) per_en <= cmd_bit_c;
            if (cmd_chg_c) chg_en <= cmd_bit_c;

            if (cmd_per_c && !cmd_bit_c) per_cnt <= '0;
            else if (per_en)             per_cnt <= per_tick_c ? '0 : per_cnt + CNT_W'(1);

            // Clears are written first so a same-cycle set wins.
            if (in_load_c) begin
                if (pend_q)      pend_q <= 1'b0;
                else if (pend_c) pend_c <= 1'b0;
                else             pend_p <= 1'b0;
            end
            if (cmd_per_c && !cmd_bit_c) pend_p <= 1'b0;
            if (cmd_chg_c && !cmd_bit_c) pend_c <= 1'b0;

            if (cmd_query_c)     pend_q <= 1'b1;
            if (chg_en && chg_c) pend_c <= 1'b1;
            if (per_tick_c)      pend_p <= 1'b1;
        end
    end

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            seq_num      <= '0;
            tx_byte_vld  <= 1'b0;
            tx_byte_data <= '0;
            frame        <= '0;
            idx          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_pend_c) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A flag withdrawn by a disable command leaves nothing to send.
                    if (any_pend_c) begin
                        frame        <= build_frame(seq_num, cause_c, sts_s, ctrl_echo);
                        tx_byte_data <= HDR_BYTE;
                        tx_byte_vld  <= 1'b1;
                        idx          <= '0;
                        state        <= ST_SEND;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (tx_byte_rdy) begin
                        if (idx == 3'd7) begin
                            tx_byte_vld <= 1'b0;
                            seq_num     <= seq_num + 8'd1;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end else begin
                            idx          <= idx + 3'd1;
                            tx_byte_data <= frame[idx + 3'd1];
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    tx_byte_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_status_report.sv
// Scoreboard bench for rf_status_report: expected bytes are queued at stimulus
// time and a negedge monitor checks every accepted byte.
module tb_rf_status_report;

    localparam logic [31:0] C_QUERY  = 32'h1b1b_3f01;
    localparam logic [31:0] C_PER_EN = 32'h1b1b_3f02;
    localparam logic [31:0] C_CHG_EN = 32'h1b1b_3f03;

    logic        clk_20mhz = 1'b0;
    logic        rst_n;
    logic        rv_uart_vld;
    logic [63:0] rv_uart_data;
    logic [15:0] rf_sts_in;
    logic [7:0]  ctrl_echo;
    logic        tx_byte_rdy;
    logic        tx_byte_vld;
    logic [7:0]  tx_byte_data;
    logic        busy;
    logic [7:0]  seq_num;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  exp_q[$];
    int          rise_q[$];
    logic        vld_prev = 1'b0;
    logic [7:0]  exp_seq;
    int          n_at;

    rf_status_report #(
        .PERIOD_CYC  (100),
        .SYNC_STAGES (2)
    ) dut (
        .clk_20mhz    (clk_20mhz),
        .rst_n        (rst_n),
        .rv_uart_vld  (rv_uart_vld),
        .rv_uart_data (rv_uart_data),
        .rf_sts_in    (rf_sts_in),
        .ctrl_echo    (ctrl_echo),
        .tx_byte_rdy  (tx_byte_rdy),
        .tx_byte_vld  (tx_byte_vld),
        .tx_byte_data (tx_byte_data),
        .busy         (busy),
        .seq_num      (seq_num)
    );

    always #25 clk_20mhz = ~clk_20mhz;
    always @(posedge clk_20mhz) cyc <= cyc + 1;

    // Monitor: pops one expected byte per accepted byte, checks stalls hold data.
    always @(negedge clk_20mhz) begin
        logic [7:0] e;
        if (rst_n) begin
            if (tx_byte_vld && !vld_prev) rise_q.push_back(cyc);
            if (tx_byte_vld && tx_byte_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h, required no byte", tx_byte_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_byte_data !== e) begin
                        n_fail++;
                        $display("FAIL frame_byte: got %02h, required %02h (cyc %0d)", tx_byte_data, e, cyc);
                    end
                end
            end else if (tx_byte_vld && exp_q.size() > 0) begin
                n_cmp++;
                if (tx_byte_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL stall_data: got %02h, required %02h", tx_byte_data, exp_q[0]);
                end
            end
        end
        vld_prev = tx_byte_vld;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[63-8*i -: 8]);
    endtask

    task automatic push_frame(input logic [7:0] seq, input logic [7:0] cause,
                              input logic [15:0] sts, input logic [7:0] ctrl);
        logic [7:0] b[8];
        b[0] = 8'h1c; b[1] = 8'h1c; b[2] = seq; b[3] = cause;
        b[4] = sts[15:8]; b[5] = sts[7:0]; b[6] = ctrl;
        b[7] = 8'h00;
        for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endtask

    // Called just after an edge; the command is sampled at the next edge (returned cycle).
    task automatic send_cmd(input logic [31:0] code, input logic [31:0] lo, output int n_edge);
        rv_uart_vld  = 1'b1;
        rv_uart_data = {code, lo};
        @(posedge clk_20mhz);
        #1;
        rv_uart_vld  = 1'b0;
        rv_uart_data = '0;
        n_edge = cyc;
    endtask

    task automatic wait_done(input string name);
        int  k  = 0;
        bit  ok = 1'b0;
        while (!ok && k < 2000) begin
            @(negedge clk_20mhz);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
            k++;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_20mhz);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rv_uart_vld  = 1'b0;
        rv_uart_data = '0;
        rf_sts_in    = 16'ha55a;
        ctrl_echo    = 8'h3c;
        tx_byte_rdy  = 1'b1;
        exp_seq      = 8'd0;
        repeat (3) @(posedge clk_20mhz);
        #1;
        check("rst_vld",  {31'd0, tx_byte_vld}, 32'd0);
        check("rst_data", {24'd0, tx_byte_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_seq",  {24'd0, seq_num}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk_20mhz);
        #1;

        // Basic query with latency check.
        rise_q.delete();
        push_word(64'h1c1c_0001_a55a_3cc2);
        send_cmd(C_QUERY, 32'h0, n_at);
        wait_done("query");
        check("query_rise_latency", rise_q.size() > 0 ? rise_q[0] - n_at : -1, 32'd2);
        check("query_seq_after", {24'd0, seq_num}, 32'd1);
        exp_seq = 8'd1;

        // Backpressure at byte 3 for 5 cycles.
        push_word(64'h1c1c_0101_a55a_3cc3);
        send_cmd(C_QUERY, 32'h0, n_at);
        repeat (5) @(posedge clk_20mhz);
        #1;
        tx_byte_rdy = 1'b0;
        repeat (5) @(posedge clk_20mhz);
        #1;
        check("stall_vld_held", {31'd0, tx_byte_vld}, 32'd1);
        tx_byte_rdy = 1'b1;
        wait_done("backpressure");
        exp_seq = 8'd2;

        // Periodic frames, then disable.
        rise_q.delete();
        for (int i = 0; i < 3; i++) push_frame(exp_seq + 8'(i), 8'h02, 16'ha55a, 8'h3c);
        send_cmd(C_PER_EN, 32'h1, n_at);
        wait_done("periodic");
        send_cmd(C_PER_EN, 32'h0, n_at);
        repeat (300) @(posedge clk_20mhz);
        #1;
        check("periodic_count", rise_q.size(), 32'd3);
        if (rise_q.size() == 3) begin
            check("periodic_gap1", rise_q[1] - rise_q[0], 32'd100);
            check("periodic_gap2", rise_q[2] - rise_q[1], 32'd100);
        end
        exp_seq = exp_seq + 8'd3;

        // Change and query collide during an in-flight frame.
        send_cmd(C_CHG_EN, 32'h1, n_at);
        repeat (3) @(posedge clk_20mhz);
        #1;
        rise_q.delete();
        push_frame(exp_seq,        8'h01, 16'ha55a, 8'h3c);
        push_frame(exp_seq + 8'd1, 8'h01, 16'ha55b, 8'h3c);
        push_frame(exp_seq + 8'd2, 8'h03, 16'ha55b, 8'h3c);
        send_cmd(C_QUERY, 32'h0, n_at);
        repeat (3) @(posedge clk_20mhz);
        #1;
        rf_sts_in = 16'ha55b;
        send_cmd(C_QUERY, 32'h0, n_at);
        wait_done("collision");
        repeat (50) @(posedge clk_20mhz);
        #1;
        check("collision_frames", rise_q.size(), 32'd3);
        exp_seq = exp_seq + 8'd3;

        // 256 queries cover the sequence wrap.
        for (int i = 0; i < 256; i++) begin
            ctrl_echo = 8'(i * 7 + 1);
            push_frame(exp_seq, 8'h01, 16'ha55b, ctrl_echo);
            send_cmd(C_QUERY, 32'h0, n_at);
            wait_done("wrap");
            exp_seq = exp_seq + 8'd1;
        end
        check("wrap_seq", {24'd0, seq_num}, {24'd0, exp_seq});

        // Reset asserted while byte 4 is on the bus.
        push_frame(exp_seq, 8'h01, 16'ha55b, ctrl_echo);
        send_cmd(C_QUERY, 32'h0, n_at);
        repeat (6) @(posedge clk_20mhz);
        #5;
        check("pre_reset_vld", {31'd0, tx_byte_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_vld_async", {31'd0, tx_byte_vld}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk_20mhz);
        #1;
        rst_n = 1'b1;
        rise_q.delete();
        @(posedge clk_20mhz);
        #1;
        check("post_reset_seq",  {24'd0, seq_num}, 32'd0);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        repeat (300) @(posedge clk_20mhz);
        #1;
        check("post_reset_no_frame", rise_q.size(), 32'd0);
        check("post_reset_idle_vld", {31'd0, tx_byte_vld}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

endmodule
